// File: rtl/bike_pkg.sv
// Shared types and constants for the bike computer datapath blocks.
// The divider arbiter states and the divider error value live here.
package bike_pkg;

    localparam int WIDTH_DIV = 16;
    localparam logic [WIDTH_DIV-1:0] DIV_ERR_VALUE = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_READY,
        DELIVER
    } div_arb_state_t;

    // Timeout counters must hold the larger of the two limits.
    function automatic int timeout_cnt_width(input int busy_to, input int done_to);
        return $clog2((busy_to > done_to) ? busy_to : done_to) + 1;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin encoder: picks the first set request strictly
// after the last winner, wrapping around to the last winner itself.
module rr_picker
    import bike_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        // Walk offsets from farthest to nearest so the nearest set bit wins.
        for (int off = N_REQ; off >= 1; off--) begin
            sum = {1'b0, last} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_REQ))
                sum = sum - (IDX_W+1)'(N_REQ);
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N_REQ requesters: round-robin grant,
// start/busy/ready handshake with timeouts, one-cycle done back to the winner.
module div_arbiter
    import bike_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DIV,
    parameter int N_REQ        = 3,
    parameter int BUSY_TIMEOUT = 4,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_dividend,
    input  logic [N_REQ*WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    output logic                   div_start,
    input  logic                   div_busy,
    input  logic                   div_ready,
    input  logic [WIDTH-1:0]       div_quotient
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = timeout_cnt_width(BUSY_TIMEOUT, DONE_TIMEOUT);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ERR_RESULT = '1;

    div_arb_state_t   state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             need_done;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [WIDTH-1:0] dividend_arr [N_REQ];
    logic [WIDTH-1:0] divisor_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign dividend_arr[i] = req_dividend[i*WIDTH +: WIDTH];
        assign divisor_arr[i]  = req_divisor[i*WIDTH +: WIDTH];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req         (req),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= IDX_W'(N_REQ - 1);
            idx          <= '0;
            cnt          <= '0;
            need_done    <= 1'b0;
            ack          <= '0;
            done         <= '0;
            err          <= 1'b0;
            result       <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            ack       <= '0;
            done      <= '0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_valid) begin
                        idx            <= grant_idx;
                        ack[grant_idx] <= 1'b1;
                        div_dividend   <= dividend_arr[grant_idx];
                        div_divisor    <= divisor_arr[grant_idx];
                        // A zero divisor never reaches the divider.
                        if (divisor_arr[grant_idx] == '0) begin
                            need_done <= 1'b1;
                            state     <= DELIVER;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (div_ready) begin
                        done[idx] <= 1'b1;
                        result    <= div_quotient;
                        err       <= 1'b0;
                        cnt       <= '0;
                        state     <= DELIVER;
                    end else if (div_busy) begin
                        cnt   <= '0;
                        state <= WAIT_READY;
                    end else if (cnt == BUSY_LAST) begin
                        done[idx] <= 1'b1;
                        result    <= ERR_RESULT;
                        err       <= 1'b1;
                        cnt       <= '0;
                        state     <= DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (div_ready) begin
                        done[idx] <= 1'b1;
                        result    <= div_quotient;
                        err       <= 1'b0;
                        cnt       <= '0;
                        state     <= DELIVER;
                    end else if (cnt == DONE_LAST) begin
                        done[idx] <= 1'b1;
                        result    <= ERR_RESULT;
                        err       <= 1'b1;
                        cnt       <= '0;
                        state     <= DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    cnt <= '0;
                    // Divide-by-zero arrives here alongside ack, so its done goes out a cycle later.
                    if (need_done) begin
                        done[idx] <= 1'b1;
                        result    <= ERR_RESULT;
                        err       <= 1'b1;
                        need_done <= 1'b0;
                    end else begin
                        last  <= idx;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
